div_sequencer: RTL and testbench
================================

// Module: div_sequencer
// PURPOSE
//  Multi-cycle sequencer for RV32M divide/remainder (ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU) in the EX stage.
//  Accepts one operation from EX, runs a radix-2 restoring divider one quotient bit per cycle,
//  and holds the pipeline via stall_o until the result is returned. MUL ops stay in the single-cycle ALU.
// PARAMETERS
//  XLEN       32 (= common::XLEN_WIDTH)  operand/result width
//  CNT_W      $clog2(XLEN)+1             iteration counter width (localparam, derived)
// PORTS
//  clk        in   1     clock, all state updates on rising edge
//  reset_n    in   1     synchronous active-low reset
//  start_i    in   1     EX presents a divide op this cycle
//  op_i       in   5     alu_op_type; only DIV/DIVU/REM/REMU are accepted
//  a_i        in   XLEN  dividend (rs1 data)
//  b_i        in   XLEN  divisor (rs2 data)
//  flush_i    in   1     branch mispredict/redirect; aborts in-flight op
//  stall_o    out  1     hold PC, IF/ID and ID/EX registers
//  busy_o     out  1     sequencer not in DIV_IDLE
//  done_o     out  1     one-cycle pulse, result_o valid
//  result_o   out  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU)
// BEHAVIOUR
//  - Reset (reset_n=0 at clk edge): state=DIV_IDLE, counter=0, stall_o=0, busy_o=0, done_o=0, result_o=0.
//    Reset wins over start_i/flush_i and aborts any in-flight op.
//  - FSM DIV_IDLE -> DIV_BUSY -> DIV_DONE -> DIV_IDLE.
//    IDLE: start_i & div-op & !flush_i at edge T -> latch |a|,|b|, signs, op; counter=XLEN; go BUSY.
//      start_i with a non-divide op is ignored (stays IDLE, stall_o=0).
//    BUSY: one shift-subtract step per cycle, counter-1; at counter==1 -> DONE. Cycles T+1..T+XLEN.
//    DONE (cycle T+XLEN+1): done_o=1, result_o valid; stall_o=0 so the pipeline captures result; next -> IDLE.
//  - stall_o = (IDLE & start_i & div-op & !flush_i) | BUSY (combinational). busy_o = BUSY|DONE.
//  - start_i while BUSY/DONE is ignored (EX is stalled and re-presents nothing new).
//  - flush_i in IDLE/BUSY/DONE: next state IDLE, no done_o pulse; flush_i has priority over start_i.
//  - Signed ops: divide magnitudes; quotient negated iff sign(a)^sign(b); remainder takes sign(a).
//  - Divide by zero (b==0): quotient=all ones, remainder=a, no sign fixup applied.
//  - Overflow DIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0 (falls out of magnitude path).
//  - result_o holds last value outside DONE; consumers qualify with done_o.
// CONFIGURATION
//  DIV_ZERO_FASTPATH_EN defined: b==0 detected in IDLE -> skip BUSY, DONE at T+1 with div-by-zero results.
//  Undefined: b==0 runs full XLEN iterations; identical results, done at T+XLEN+1.
// STRUCTURE
//  Package common gets: typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_type;
//   function logic is_div_op(alu_op_type op) (true for DIV/DIVU/REM/REMU).
//  Sub-module div_iter_step: combinational one restoring step
//   (in: partial rem, quotient, divisor; out: next rem, next quotient). Sequencer owns FSM, counter, sign fixup.
// TESTING
//  1 DIVU a=100 b=7 -> stall_o high T..T+32, done_o at T+33, result_o=14; REMU same -> 2.
//  2 DIV a=-7 b=2 -> result_o=0xFFFFFFFD (-3); REM a=-7 b=2 -> 0xFFFFFFFF (-1).
//  3 DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000; REM -> 0.
//  4 DIVU a=5 b=0 -> 0xFFFFFFFF; REM a=-5 b=0 -> 0xFFFFFFFB; done at T+1 with macro, T+33 without.
//  5 flush_i at T+10 -> busy_o=0 at T+11, no done_o ever; new start at T+11 completes normally.
//  6 reset_n=0 at T+5 -> all outputs 0 next cycle; start_i with op_i=ALU_MUL in IDLE -> stall_o=0, no state change.

Source files
------------

// File: rtl/div_sequencer_pkg.sv
// Shared ALU definitions: operand width, ALU op encoding, divider FSM states and op-class helpers.
package common;
   localparam int XLEN_WIDTH = 32;

   typedef enum logic [4:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
      ALU_OR, ALU_AND, ALU_LUI, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
   } alu_op_type;

   typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_type;

   function automatic logic is_div_op(alu_op_type op);
      return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
   endfunction

   function automatic logic is_signed_div(alu_op_type op);
      return (op == ALU_DIV) || (op == ALU_REM);
   endfunction

   function automatic logic is_rem_op(alu_op_type op);
      return (op == ALU_REM) || (op == ALU_REMU);
   endfunction
endpackage

// File: rtl/div_sequencer_step.sv
// One radix-2 restoring divide step: shift the next dividend bit into the partial remainder,
// subtract the divisor if it fits, and shift the resulting quotient bit in.
module div_iter_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem_i,
   input  logic [XLEN-1:0] quo_i,
   input  logic [XLEN-1:0] dvsr_i,
   output logic [XLEN-1:0] rem_o,
   output logic [XLEN-1:0] quo_o
);
   logic [XLEN:0]   shifted;
   logic [XLEN-1:0] diff;
   logic            ge;

   // quo_i doubles as the dividend shift register, so its MSB feeds the remainder.
   assign shifted = {rem_i, quo_i[XLEN-1]};
   assign ge      = shifted >= {1'b0, dvsr_i};
   // Low bits of the difference are exact whenever ge holds; the result is < divisor.
   assign diff    = shifted[XLEN-1:0] - dvsr_i;
   assign rem_o   = ge ? diff : shifted[XLEN-1:0];
   assign quo_o   = {quo_i[XLEN-2:0], ge};
endmodule

// File: rtl/div_sequencer.sv
// RV32M divide/remainder sequencer: one quotient bit per cycle, stalls EX until DONE.
// Optional DIV_ZERO_FASTPATH_EN: a zero divisor skips iteration and finishes the cycle after start.
module div_sequencer
   import common::*;
#(
   parameter int XLEN = XLEN_WIDTH
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start_i,
   input  logic [4:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);
   localparam int CNT_W = $clog2(XLEN) + 1;

   div_state_type   state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d, result_q, result_d;
   logic            qneg_q, qneg_d, rneg_q, rneg_d, remop_q, remop_d, bzero_q, bzero_d;

   alu_op_type      op;
   logic            accept, a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag, rem_nx, quo_nx, q_fix, r_fix, res;

   assign op     = alu_op_type'(op_i);
   assign accept = (state_q == DIV_IDLE) && start_i && is_div_op(op) && !flush_i;
   assign a_neg  = is_signed_div(op) && a_i[XLEN-1];
   assign b_neg  = is_signed_div(op) && b_i[XLEN-1];
   assign a_mag  = a_neg ? -a_i : a_i;
   assign b_mag  = b_neg ? -b_i : b_i;

   div_iter_step #(.XLEN(XLEN)) u_step (
      .rem_i  (rem_q),
      .quo_i  (quo_q),
      .dvsr_i (dvsr_q),
      .rem_o  (rem_nx),
      .quo_o  (quo_nx)
   );

   // Divide by zero: quotient forced to all ones; the magnitude remainder is |a|, and
   // re-applying sign(a) reproduces a exactly, so the remainder needs no special case.
   assign q_fix = bzero_q ? {XLEN{1'b1}} : (qneg_q ? -quo_q : quo_q);
   assign r_fix = rneg_q ? -rem_q : rem_q;
   assign res   = remop_q ? r_fix : q_fix;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvsr_d   = dvsr_q;
      result_d = result_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      remop_d  = remop_q;
      bzero_d  = bzero_q;
      case (state_q)
         DIV_IDLE: begin
            if (accept) begin
               rem_d   = '0;
               quo_d   = a_mag;
               dvsr_d  = b_mag;
               qneg_d  = a_neg ^ b_neg;
               rneg_d  = a_neg;
               remop_d = is_rem_op(op);
               bzero_d = (b_i == '0);
               cnt_d   = CNT_W'(XLEN);
               state_d = DIV_BUSY;
`ifdef DIV_ZERO_FASTPATH_EN
               if (b_i == '0) begin
                  rem_d   = a_mag;
                  quo_d   = {XLEN{1'b1}};
                  cnt_d   = '0;
                  state_d = DIV_DONE;
               end
`endif
            end
         end
         DIV_BUSY: begin
            rem_d = rem_nx;
            quo_d = quo_nx;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = DIV_DONE;
         end
         DIV_DONE: begin
            state_d = DIV_IDLE;
            if (!flush_i) result_d = res;
         end
         default: state_d = DIV_IDLE;
      endcase
      if (flush_i) state_d = DIV_IDLE;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= DIV_IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvsr_q   <= '0;
         result_q <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         remop_q  <= 1'b0;
         bzero_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvsr_q   <= dvsr_d;
         result_q <= result_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         remop_q  <= remop_d;
         bzero_q  <= bzero_d;
      end
   end

   assign stall_o  = accept || (state_q == DIV_BUSY);
   assign busy_o   = (state_q != DIV_IDLE);
   assign done_o   = (state_q == DIV_DONE) && !flush_i;
   assign result_o = done_o ? res : result_q;
endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: latency, stall window, signed/unsigned results, flush and reset.
module tb_div_sequencer;
   import common::*;

`ifdef DIV_ZERO_FASTPATH_EN
   localparam int ZLAT = 1;
`else
   localparam int ZLAT = 33;
`endif

   logic        clk = 1'b0;
   logic        reset_n, start_i, flush_i;
   logic [4:0]  op_i;
   logic [31:0] a_i, b_i;
   logic        stall_o, busy_o, done_o;
   logic [31:0] result_o;
   int          passed = 0;
   int          total  = 0;

   always #5 clk = ~clk;

   div_sequencer dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start_i  (start_i),
      .op_i     (op_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .flush_i  (flush_i),
      .stall_o  (stall_o),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .result_o (result_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Caller is positioned just after a falling edge (cycle T).
   task automatic run_op(input string tag, input alu_op_type op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
      int   n;
      logic stall_ok;
      start_i = 1'b1; op_i = op; a_i = a; b_i = b;
      #1 chk({tag, "_stallT"}, {31'b0, stall_o}, 32'd1);
      @(negedge clk);
      start_i = 1'b0; a_i = '0; b_i = '0;
      n = 1; stall_ok = 1'b1;
      while (done_o !== 1'b1 && n < 60) begin
         if (stall_o !== 1'b1 || busy_o !== 1'b1) stall_ok = 1'b0;
         @(negedge clk);
         n++;
      end
      chk({tag, "_lat"}, 32'(n), 32'(lat));
      chk({tag, "_stallwin"}, {31'b0, stall_ok}, 32'd1);
      chk({tag, "_stalldone"}, {31'b0, stall_o}, 32'd0);
      chk({tag, "_result"}, result_o, exp);
      @(negedge clk);
      chk({tag, "_idle"}, {30'b0, busy_o, done_o}, 32'd0);
   endtask

   initial begin
      logic done_seen;
      reset_n = 1'b0; start_i = 1'b0; flush_i = 1'b0; op_i = ALU_ADD; a_i = '0; b_i = '0;
      repeat (3) @(negedge clk);
      chk("rst_stall", {31'b0, stall_o}, 32'd0);
      chk("rst_busy", {31'b0, busy_o}, 32'd0);
      chk("rst_done", {31'b0, done_o}, 32'd0);
      chk("rst_result", result_o, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      run_op("divu", ALU_DIVU, 32'd100, 32'd7, 32'd14, 33);
      run_op("remu", ALU_REMU, 32'd100, 32'd7, 32'd2, 33);
      run_op("div_neg", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
      run_op("rem_neg", ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
      run_op("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
      run_op("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
      run_op("divu_z", ALU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, ZLAT);
      run_op("rem_z", ALU_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, ZLAT);
      run_op("div_z", ALU_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, ZLAT);
      run_op("divu_big", ALU_DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 33);

      // Flush in cycle T+10 of an in-flight divide.
      start_i = 1'b1; op_i = ALU_DIVU; a_i = 32'd100; b_i = 32'd7;
      @(negedge clk);
      start_i = 1'b0;
      done_seen = 1'b0;
      repeat (9) begin
         if (done_o === 1'b1) done_seen = 1'b1;
         @(negedge clk);
      end
      flush_i = 1'b1;
      #1 if (done_o !== 1'b0) done_seen = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      chk("flush_busy", {31'b0, busy_o}, 32'd0);
      chk("flush_nodone", {31'b0, done_seen | done_o}, 32'd0);
      run_op("flush_new", ALU_DIVU, 32'd50, 32'd6, 32'd8, 33);

      // Reset at cycle T+5 of an in-flight op.
      start_i = 1'b1; op_i = ALU_REMU; a_i = 32'd100; b_i = 32'd7;
      @(negedge clk);
      start_i = 1'b0;
      repeat (4) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      chk("midrst_stall", {31'b0, stall_o}, 32'd0);
      chk("midrst_busy", {31'b0, busy_o}, 32'd0);
      chk("midrst_done", {31'b0, done_o}, 32'd0);
      chk("midrst_result", result_o, 32'd0);
      reset_n = 1'b1;

      // A MUL op must not start the sequencer.
      start_i = 1'b1; op_i = ALU_MUL; a_i = 32'd3; b_i = 32'd4;
      #1 chk("mul_stall", {31'b0, stall_o}, 32'd0);
      @(negedge clk);
      start_i = 1'b0;
      chk("mul_busy", {31'b0, busy_o}, 32'd0);
      chk("mul_done", {31'b0, done_o}, 32'd0);
      run_op("post_rst", ALU_REMU, 32'd1000, 32'd33, 32'd10, 33);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
